frog_controller: RTL

FROG_CONTROLLER -- requirements
Module: frog_controller

---
 rtl/frog_controller.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/frog_controller.sv
// Frog sprite controller: button edges start 32-px hops animated over frame ticks; hits kill and respawn.
// Optional macro FROG_LIVES_EN adds a three-life counter and a GAME_OVER state.
module frog_controller #(
  parameter int START_X     = 304,
  parameter int START_Y     = 448,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int HOP_FRAMES  = 8,
  parameter int DEAD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       hit,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic [1:0] direction,
  output logic       moving,
  output logic       dead,
  output logic       hop_done,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [9:0]    STEP      = 10'(32 / HOP_FRAMES);
  localparam logic [9:0]    HOP_PX    = 10'd32;
  localparam logic [10:0]   MAX_X     = 11'(SCREEN_W - 32);
  localparam logic [10:0]   MAX_Y     = 11'(SCREEN_H - 32);
  localparam logic [9:0]    SPAWN_X   = 10'(START_X);
  localparam logic [9:0]    SPAWN_Y   = 10'(START_Y);
  localparam logic [4:0]    HOP_LAST  = 5'(HOP_FRAMES - 1);
  localparam int            DW        = $clog2(DEAD_FRAMES + 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_FRAMES - 1);

  // Encoding matches the renderer's sprite bank order.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOP,
    S_DEAD
`ifdef FROG_LIVES_EN
    , S_GAME_OVER
`endif
  } state_t;

  state_t        r_state, w_state_nxt;
  dir_t          r_dir, w_dir_nxt, w_req_dir;
  logic [9:0]    r_x, r_y, w_x_nxt, w_y_nxt;
  logic [9:0]    r_tgt_x, r_tgt_y, w_tgt_x_nxt, w_tgt_y_nxt;
  logic [9:0]    w_req_x, w_req_y;
  logic          w_req_ok;
  logic [4:0]    r_hop_cnt, w_hop_cnt_nxt;
  logic [DW-1:0] r_dead_cnt, w_dead_cnt_nxt;
  logic [3:0]    r_btn_prev;
  logic [3:0]    w_btn, w_edge;
  logic          w_enter_dead, w_respawn, w_hop_done_nxt;
  logic          r_moving, r_dead, r_hop_done;
`ifdef FROG_LIVES_EN
  logic [1:0]    r_lives, w_lives_nxt;
  logic          r_game_over;
`endif

  assign w_btn        = {btn_right, btn_left, btn_down, btn_up};
  assign w_edge       = w_btn & ~r_btn_prev;
  assign w_enter_dead = hit && (r_state == S_IDLE || r_state == S_HOP);

  // NOTE: every signal driven here gets a default first; a path that skips one would infer a latch.
  always_comb begin
    w_req_dir = DIR_RIGHT;
    if (w_edge[0])      w_req_dir = DIR_UP;
    else if (w_edge[1]) w_req_dir = DIR_DOWN;
    else if (w_edge[2]) w_req_dir = DIR_LEFT;
  end

  // Bounds are checked in 11 bits so +32 near the top of the range cannot wrap.
  always_comb begin
    w_req_x  = r_x;
    w_req_y  = r_y;
    w_req_ok = 1'b0;
    unique case (w_req_dir)
      DIR_UP: begin
        w_req_y  = r_y - HOP_PX;
        w_req_ok = (r_y >= HOP_PX);
      end
      DIR_DOWN: begin
        w_req_y  = r_y + HOP_PX;
        w_req_ok = (({1'b0, r_y} + 11'd32) <= MAX_Y);
      end
      DIR_LEFT: begin
        w_req_x  = r_x - HOP_PX;
        w_req_ok = (r_x >= HOP_PX);
      end
      DIR_RIGHT: begin
        w_req_x  = r_x + HOP_PX;
        w_req_ok = (({1'b0, r_x} + 11'd32) <= MAX_X);
      end
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_tgt_x_nxt    = r_tgt_x;
    w_tgt_y_nxt    = r_tgt_y;
    w_dir_nxt      = r_dir;
    w_hop_cnt_nxt  = r_hop_cnt;
    w_dead_cnt_nxt = r_dead_cnt;
    w_hop_done_nxt = 1'b0;
    w_respawn      = 1'b0;
`ifdef FROG_LIVES_EN
    w_lives_nxt    = r_lives;
`endif
    // A hit outranks both button edges and hop completion; position stays where it is.
    if (w_enter_dead) begin
      w_state_nxt    = S_DEAD;
      w_dead_cnt_nxt = '0;
      w_hop_cnt_nxt  = '0;
`ifdef FROG_LIVES_EN
      w_lives_nxt    = r_lives - 2'd1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_edge) begin
            w_dir_nxt = w_req_dir;
            if (w_req_ok) begin
              w_state_nxt   = S_HOP;
              w_tgt_x_nxt   = w_req_x;
              w_tgt_y_nxt   = w_req_y;
              w_hop_cnt_nxt = '0;
            end
          end
        end
        S_HOP: begin
          if (frame_tick) begin
            if (r_hop_cnt == HOP_LAST) begin
              w_x_nxt        = r_tgt_x;
              w_y_nxt        = r_tgt_y;
              w_hop_cnt_nxt  = '0;
              w_hop_done_nxt = 1'b1;
              w_state_nxt    = S_IDLE;
            end else begin
              w_hop_cnt_nxt = r_hop_cnt + 5'd1;
              unique case (r_dir)
                DIR_UP:    w_y_nxt = r_y - STEP;
                DIR_DOWN:  w_y_nxt = r_y + STEP;
                DIR_LEFT:  w_x_nxt = r_x - STEP;
                DIR_RIGHT: w_x_nxt = r_x + STEP;
              endcase
            end
          end
        end
        S_DEAD: begin
          if (frame_tick) begin
            if (r_dead_cnt == DEAD_LAST) begin
              w_dead_cnt_nxt = '0;
`ifdef FROG_LIVES_EN
              if (r_lives == 2'd0) w_state_nxt = S_GAME_OVER;
              else                 w_respawn   = 1'b1;
`else
              w_respawn = 1'b1;
`endif
            end else begin
              w_dead_cnt_nxt = r_dead_cnt + DW'(1);
            end
          end
        end
`ifdef FROG_LIVES_EN
        S_GAME_OVER: begin
          if (|w_edge) begin
            w_respawn   = 1'b1;
            w_lives_nxt = 2'd3;
          end
        end
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end
    if (w_respawn) begin
      w_x_nxt     = SPAWN_X;
      w_y_nxt     = SPAWN_Y;
      w_dir_nxt   = DIR_UP;
      w_state_nxt = S_IDLE;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_x        <= SPAWN_X;
      r_y        <= SPAWN_Y;
      r_tgt_x    <= SPAWN_X;
      r_tgt_y    <= SPAWN_Y;
      r_dir      <= DIR_UP;
      r_hop_cnt  <= '0;
      r_dead_cnt <= '0;
      r_btn_prev <= '0;
      r_moving   <= 1'b0;
      r_dead     <= 1'b0;
      r_hop_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_tgt_x    <= w_tgt_x_nxt;
      r_tgt_y    <= w_tgt_y_nxt;
      r_dir      <= w_dir_nxt;
      r_hop_cnt  <= w_hop_cnt_nxt;
      r_dead_cnt <= w_dead_cnt_nxt;
      r_btn_prev <= w_btn;
      r_moving   <= (w_state_nxt == S_HOP);
      r_dead     <= (w_state_nxt == S_DEAD);
      r_hop_done <= w_hop_done_nxt;
    end
  end

`ifdef FROG_LIVES_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lives     <= 2'd3;
      r_game_over <= 1'b0;
    end else begin
      r_lives     <= w_lives_nxt;
      r_game_over <= (w_state_nxt == S_GAME_OVER);
    end
  end

  assign lives     = r_lives;
  assign game_over = r_game_over;
`else
  assign lives     = 2'd3;
  assign game_over = 1'b0;
`endif

  assign frog_x    = r_x;
  assign frog_y    = r_y;
  assign direction = r_dir;
  assign moving    = r_moving;
  assign dead      = r_dead;
  assign hop_done  = r_hop_done;

endmodule
